// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_div_unit_pkg                                                 |
// | Purpose : Shared op encodings and FSM state type for the multiply/divide   |
// |           unit and the instruction decoder.                                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mul_div_unit_pkg;

  // Operation encodings carried on op_i
  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIN  = 2'd3
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_div_unit_div_step                                            |
// | Purpose : One combinational restoring-division step.                       |
// |   rem_i  partial remainder (always < divisor)                              |
// |   quo_i  dividend bits still to shift in (MSB first) / quotient so far     |
// |   div_i  divisor                                                           |
// |   rem_o  next partial remainder                                            |
// |   quo_o  next quotient/dividend shift register                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mul_div_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Bring the next dividend bit into the remainder; one extra bit holds the
  // carry so the trial subtraction's borrow lands in diff[WIDTH].
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_i};

  // Borrow set: divisor did not fit, restore the shifted remainder.
  assign rem_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_div_unit                                                     |
// | Purpose : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO      |
// |           registers; MTHI/MTLO complete in one cycle.                      |
// | Ports   : clk, rst       clock, synchronous active-high reset              |
// |           start_i, op_i  request and operation (sampled when not busy)     |
// |           a_i, b_i       rs / rt operands                                  |
// |           cancel_i       abort in-flight MULT/DIV (pipeline flush)         |
// |           busy_o         multi-cycle operation in flight                   |
// |           done_o         one-cycle pulse, hi/lo hold a new result          |
// |           hi_o, lo_o     HI / LO registers                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

  mdu_state_e       state_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] a_q, b_q;       // raw operands as issued
  logic [1:0]       mdop_q;         // low op bits: [1]=divide, [0]=unsigned
  logic [WIDTH-1:0] opnd_q;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_q;          // product high half / partial remainder
  logic [WIDTH-1:0] low_q;          // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] cnt_q;
  logic             neg_res_q;      // negate product / quotient
  logic             neg_rem_q;      // negate remainder (dividend sign)

  logic             div_op, signed_op;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d;
  logic [WIDTH-1:0] div_rem_d, div_quo_d;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] hi_d, lo_d;

  assign div_op    = mdop_q[1];
  assign signed_op = ~mdop_q[0];

  assign a_abs = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;

  // Shift-add: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole product right by one.
  assign mul_sum  = {1'b0, acc_q} + {1'b0, (low_q[0] ? opnd_q : '0)};
  assign mul_hi_d = mul_sum[WIDTH:1];
  assign mul_lo_d = {mul_sum[0], low_q[WIDTH-1:1]};

  mul_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q),
    .quo_i (low_q),
    .div_i (opnd_q),
    .rem_o (div_rem_d),
    .quo_o (div_quo_d)
  );

  assign prod     = {mul_hi_d, mul_lo_d};
  assign prod_fix = neg_res_q ? -prod : prod;

  // Final result, taken from the last step's outputs so hi/lo load on the
  // same edge that enters FIN.
  always_comb begin
    hi_d = prod_fix[2*WIDTH-1:WIDTH];
    lo_d = prod_fix[WIDTH-1:0];
    if (div_op) begin
      if (b_q == '0) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = neg_rem_q ? -div_rem_d : div_rem_d;
        lo_d = neg_res_q ? -div_quo_d : div_quo_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mdop_q    <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // FIN is not busy, so a new request is accepted there too.
        S_IDLE, S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (start_i) begin
            case (op_i)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                a_q     <= a_i;
                b_q     <= b_i;
                mdop_q  <= op_i[1:0];
                state_q <= S_PREP;
                busy_q  <= 1'b1;
              end
              MDU_MTHI: hi_q <= a_i;
              MDU_MTLO: lo_q <= a_i;
              default: begin end
            endcase
          end
        end
        S_PREP: begin
          if (cancel_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            opnd_q    <= div_op ? b_abs : a_abs;
            low_q     <= div_op ? a_abs : b_abs;
            acc_q     <= '0;
            cnt_q     <= CNT_LAST;
            neg_res_q <= signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_rem_q <= signed_op & a_q[WIDTH-1];
            state_q   <= S_CALC;
          end
        end
        S_CALC: begin
          if (cancel_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= div_op ? div_rem_d : mul_hi_d;
            low_q <= div_op ? div_quo_d : mul_lo_d;
            if (cnt_q == '0) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hi_q    <= hi_d;
              lo_q    <= lo_d;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mul_div_unit                                                  |
// | Purpose : Self-checking bench for mul_div_unit (WIDTH=32).                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         cancel_i = 1'b0;
  logic [2:0]   op_i = 3'b000;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cancel_i (cancel_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of a MULT/DIV from plain arithmetic.
  function automatic void ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] rh, output logic [W-1:0] rl);
    logic [63:0] p;
    int sa, sb;
    sa = a; sb = b; p = '0; rh = '0; rl = '0;
    case (op)
      3'b000: begin p = 64'(longint'(sa) * longint'(sb)); {rh, rl} = p; end
      3'b001: begin p = {32'b0, a} * {32'b0, b};          {rh, rl} = p; end
      3'b010: begin
        if (b == 0) begin rl = '1; rh = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = '0; end
        else begin rl = 32'(sa / sb); rh = 32'(sa % sb); end
      end
      3'b011: begin
        if (b == 0) begin rl = '1; rh = a; end
        else begin rl = a / b; rh = a % b; end
      end
      default: begin end
    endcase
  endfunction

  // Timing model: an accepted MULT/DIV keeps busy for WIDTH+1 cycles, then
  // hi/lo take the result and done pulses for one cycle.
  int           m_rem = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0, p_hi = '0, p_lo = '0;
  logic         exp_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; exp_hi = '0; exp_lo = '0; exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (m_rem > 0) begin
        if (cancel_i) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin exp_hi = p_hi; exp_lo = p_lo; exp_done = 1'b1; end
        end
      end else if (start_i) begin
        if (op_i[2] == 1'b0) begin
          ref_result(op_i, a_i, b_i, p_hi, p_lo);
          m_rem = W + 1;
        end else if (op_i == 3'b100) exp_hi = a_i;
        else if (op_i == 3'b101) exp_lo = a_i;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'b0, busy_o}, {31'b0, m_rem > 0});
      chk("cyc_done", {31'b0, done_o}, {31'b0, exp_done});
      chk("cyc_hi", hi_o, exp_hi);
      chk("cyc_lo", lo_o, exp_lo);
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
    int k;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0;
    k = 1;
    while (!done_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, W'(k), W'(34));
    chk({nm, "_hi"}, hi_o, eh);
    chk({nm, "_lo"}, lo_o, el);
  endtask

  initial begin
    int k;
    bit saw_done;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_hi", hi_o, '0);
    chk("reset_lo", lo_o, '0);
    chk("reset_busy", {31'b0, busy_o}, '0);
    chk("reset_done", {31'b0, done_o}, '0);
    chk_en = 1'b1;

    run_op(3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    // issued in the FIN cycle of the previous op
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, "multu");
    run_op(3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        "divu");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, "div_ovf");
    run_op(3'b011, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "divu_zero");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         "mult_min");
    run_op(3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_negb");

    // In-flight DIV: MTHI while busy is ignored, then cancelled.
    start_i = 1'b1; op_i = 3'b010; a_i = 32'd1000; b_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    for (k = 1; k < 10; k++) @(negedge clk);
    start_i = 1'b1; op_i = 3'b100; a_i = 32'hDEAD_BEEF;
    @(negedge clk);
    start_i = 1'b0;
    chk("mthi_busy_hi", hi_o, 32'd1);
    for (k = 11; k < 20; k++) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    chk("cancel_busy", {31'b0, busy_o}, '0);
    chk("cancel_hi", hi_o, 32'd1);
    chk("cancel_lo", lo_o, 32'hFFFF_FFFD);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    chk("cancel_no_done", {31'b0, saw_done}, '0);

    // MTLO and a reserved op.
    start_i = 1'b1; op_i = 3'b101; a_i = 32'h0000_1234;
    @(negedge clk);
    start_i = 1'b0;
    chk("mtlo_lo", lo_o, 32'h0000_1234);
    chk("mtlo_busy", {31'b0, busy_o}, '0);
    start_i = 1'b1; op_i = 3'b110; a_i = 32'h5555_5555;
    @(negedge clk);
    start_i = 1'b0;
    chk("rsvd_busy", {31'b0, busy_o}, '0);
    chk("rsvd_hi", hi_o, 32'd1);
    chk("rsvd_lo", lo_o, 32'h0000_1234);

    // start and cancel together while idle: start wins.
    start_i = 1'b1; cancel_i = 1'b1; op_i = 3'b011; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    chk("startcancel_busy", {31'b0, busy_o}, 32'd1);
    k = 1;
    while (!done_o && k < 60) begin @(negedge clk); k++; end
    chk("startcancel_latency", W'(k), W'(34));
    chk("startcancel_lo", lo_o, 32'd14);
    chk("startcancel_hi", hi_o, 32'd2);

    // Reset mid-MULT.
    start_i = 1'b1; op_i = 3'b000; a_i = 32'd3; b_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    for (k = 1; k < 5; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_hi", hi_o, '0);
    chk("rstmid_lo", lo_o, '0);
    chk("rstmid_busy", {31'b0, busy_o}, '0);
    chk("rstmid_done", {31'b0, done_o}, '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
